// File: rtl/nic_prop_pipe.sv
// nic_prop_pipe -- elastic network propagation pipe.
//
// Carries two independent channels, Packet (p) and IPacket (ip), through
// DEPTH skid-buffer stages each. Every stage registers its ready, so long
// NoC hops can be retimed without a combinational ready path.
//
// Parameters:
//   DEPTH  skid stages per channel (1..8); capacity is 2*DEPTH per channel
//   CNTW   width of the delivered-packet counters
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   p_valid_i/p_ready_o/packet_i  upstream Packet handshake + data
//   p_valid_o/p_ready_i/packet_o  downstream Packet handshake + data
//   ip_*                          same for IPacket
//   p_occ_o, ip_occ_o             entries currently held per chain
//   p_cnt_o, ip_cnt_o             saturating delivered counters
//
// Optional feature (macro NIC_PROP_PIPE_STATS_EN): when defined, p_cnt_o and
// ip_cnt_o count downstream transfers and saturate at 2^CNTW-1. When
// undefined the ports are tied to 0 and no counter flops exist.

package nic_pkg;
  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [15:0] data;
  } Packet;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] kind;
    logic [7:0] data;
  } IPacket;
endpackage

// One skid stage: main register feeds the output, skid register catches the
// beat accepted while downstream stalls (ready_o is a flop, so one beat can
// arrive after the stall is seen).
module nic_prop_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         in_xfer, out_xfer;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_o & ready_i;
  assign valid_o  = (state_q != EMPTY);
  assign data_o   = main_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (in_xfer) state_d = BUSY;
      BUSY: begin
        if (in_xfer && !out_xfer)      state_d = FULL;
        else if (!in_xfer && out_xfer) state_d = EMPTY;
      end
      FULL:    if (out_xfer) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_o <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      // ready for the next cycle is known from the next state alone
      ready_o <= (state_d != FULL);
      if (state_q == FULL) begin
        if (out_xfer) begin
          main_q <= skid_q;
          skid_q <= '0;
        end
      end else if (in_xfer) begin
        // BUSY with a stalled output parks the new beat in skid
        if (state_q == BUSY && !out_xfer) skid_q <= data_i;
        else                              main_q <= data_i;
      end
    end
  end
endmodule

module nic_prop_pipe #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          p_valid_i,
  output logic                          p_ready_o,
  input  nic_pkg::Packet                packet_i,
  output logic                          p_valid_o,
  input  logic                          p_ready_i,
  output nic_pkg::Packet                packet_o,
  input  logic                          ip_valid_i,
  output logic                          ip_ready_o,
  input  nic_pkg::IPacket               ipacket_i,
  output logic                          ip_valid_o,
  input  logic                          ip_ready_i,
  output nic_pkg::IPacket               ipacket_o,
  output logic [$clog2(2*DEPTH+1)-1:0]  p_occ_o,
  output logic [$clog2(2*DEPTH+1)-1:0]  ip_occ_o,
  output logic [CNTW-1:0]               p_cnt_o,
  output logic [CNTW-1:0]               ip_cnt_o
);
  localparam int PW  = $bits(nic_pkg::Packet);
  localparam int IPW = $bits(nic_pkg::IPacket);
  localparam int OW  = $clog2(2*DEPTH+1);

  if (DEPTH < 1 || DEPTH > 8) begin : g_depth_chk
    $error("nic_prop_pipe: DEPTH must be within 1..8");
  end

  // Index k is the link into stage k; index DEPTH is the pipe output.
  logic [DEPTH:0]           p_vld, p_rdy, ip_vld, ip_rdy;
  logic [DEPTH:0][PW-1:0]   p_dat;
  logic [DEPTH:0][IPW-1:0]  ip_dat;

  assign p_vld[0]      = p_valid_i;
  assign p_dat[0]      = packet_i;
  assign p_rdy[DEPTH]  = p_ready_i;
  assign p_ready_o     = p_rdy[0];
  assign p_valid_o     = p_vld[DEPTH];
  assign packet_o      = nic_pkg::Packet'(p_dat[DEPTH]);

  assign ip_vld[0]     = ip_valid_i;
  assign ip_dat[0]     = ipacket_i;
  assign ip_rdy[DEPTH] = ip_ready_i;
  assign ip_ready_o    = ip_rdy[0];
  assign ip_valid_o    = ip_vld[DEPTH];
  assign ipacket_o     = nic_pkg::IPacket'(ip_dat[DEPTH]);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    nic_prop_skid #(.W(PW)) u_p (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (p_vld[k]),
      .ready_o (p_rdy[k]),
      .data_i  (p_dat[k]),
      .valid_o (p_vld[k+1]),
      .ready_i (p_rdy[k+1]),
      .data_o  (p_dat[k+1])
    );
    nic_prop_skid #(.W(IPW)) u_ip (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (ip_vld[k]),
      .ready_o (ip_rdy[k]),
      .data_i  (ip_dat[k]),
      .valid_o (ip_vld[k+1]),
      .ready_i (ip_rdy[k+1]),
      .data_o  (ip_dat[k+1])
    );
  end

  logic p_in, p_out, ip_in, ip_out;
  assign p_in   = p_valid_i  & p_ready_o;
  assign p_out  = p_valid_o  & p_ready_i;
  assign ip_in  = ip_valid_i & ip_ready_o;
  assign ip_out = ip_valid_o & ip_ready_i;

  logic [OW-1:0] p_occ_q, ip_occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_occ_q  <= '0;
      ip_occ_q <= '0;
    end else begin
      if (p_in && !p_out)       p_occ_q <= p_occ_q + OW'(1);
      else if (!p_in && p_out)  p_occ_q <= p_occ_q - OW'(1);
      if (ip_in && !ip_out)     ip_occ_q <= ip_occ_q + OW'(1);
      else if (!ip_in && ip_out) ip_occ_q <= ip_occ_q - OW'(1);
    end
  end

  assign p_occ_o  = p_occ_q;
  assign ip_occ_o = ip_occ_q;

`ifdef NIC_PROP_PIPE_STATS_EN
  logic [CNTW-1:0] p_cnt_q, ip_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_cnt_q  <= '0;
      ip_cnt_q <= '0;
    end else begin
      if (p_out && !(&p_cnt_q))   p_cnt_q  <= p_cnt_q + CNTW'(1);
      if (ip_out && !(&ip_cnt_q)) ip_cnt_q <= ip_cnt_q + CNTW'(1);
    end
  end

  assign p_cnt_o  = p_cnt_q;
  assign ip_cnt_o = ip_cnt_q;
`else
  assign p_cnt_o  = '0;
  assign ip_cnt_o = '0;
`endif
endmodule

// File: tb/tb_nic_prop_pipe.sv
// Scoreboard bench for nic_prop_pipe (DEPTH=2, CNTW=4).
module tb_nic_prop_pipe;
  import nic_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNTW  = 4;
  localparam int OW    = $clog2(2*DEPTH+1);

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic p_valid_i, p_ready_o, p_valid_o, p_ready_i;
  logic ip_valid_i, ip_ready_o, ip_valid_o, ip_ready_i;
  Packet  packet_i, packet_o;
  IPacket ipacket_i, ipacket_o;
  logic [OW-1:0]   p_occ_o, ip_occ_o;
  logic [CNTW-1:0] p_cnt_o, ip_cnt_o;

  nic_prop_pipe #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .p_valid_i(p_valid_i), .p_ready_o(p_ready_o), .packet_i(packet_i),
    .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .packet_o(packet_o),
    .ip_valid_i(ip_valid_i), .ip_ready_o(ip_ready_o), .ipacket_i(ipacket_i),
    .ip_valid_o(ip_valid_o), .ip_ready_i(ip_ready_i), .ipacket_o(ipacket_o),
    .p_occ_o(p_occ_o), .ip_occ_o(ip_occ_o),
    .p_cnt_o(p_cnt_o), .ip_cnt_o(ip_cnt_o)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [31:0] p_stim[$], p_exp[$];
  logic [15:0] ip_stim[$], ip_exp[$];
  int p_acc = 0, p_del = 0, ip_acc = 0, ip_del = 0;
  int p_gate = 100, ip_gate = 100;
  bit chk_occ = 0, strm = 0, rnd = 0;
  int strm_max_occ, strm_gaps, strm_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic p_send(input logic [31:0] v);
    p_stim.push_back(v);
    p_exp.push_back(v);
  endtask

  task automatic ip_send(input logic [15:0] v);
    ip_stim.push_back(v);
    ip_exp.push_back(v);
  endtask

  function automatic int sat(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic chk_stats(input string nm);
`ifdef NIC_PROP_PIPE_STATS_EN
    chk({nm, "_p_cnt"},  p_cnt_o,  sat(p_del));
    chk({nm, "_ip_cnt"}, ip_cnt_o, sat(ip_del));
`else
    chk({nm, "_p_cnt"},  p_cnt_o,  0);
    chk({nm, "_ip_cnt"}, ip_cnt_o, 0);
`endif
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int n = 0;
    while (n < lim && (p_exp.size() != 0 || ip_exp.size() != 0)) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk(nm, p_exp.size() + ip_exp.size(), 0);
  endtask

  // Monitor: occupancy model, acceptance count, output scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (chk_occ) begin
        chk("p_occ",  p_occ_o,  p_acc - p_del);
        chk("ip_occ", ip_occ_o, ip_acc - ip_del);
      end
      if (strm && int'(p_occ_o) > strm_max_occ) strm_max_occ = p_occ_o;
      if (p_valid_i && p_ready_o) p_acc++;
      if (ip_valid_i && ip_ready_o) ip_acc++;
      if (p_valid_o && p_ready_i) begin
        if (p_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL p_spurious: got packet %0h want none", packet_o);
        end else chk("p_data", packet_o, p_exp.pop_front());
        p_del++;
        if (strm) begin
          if (strm_last >= 0 && cyc - strm_last != 1) strm_gaps++;
          strm_last = cyc;
        end
      end
      if (ip_valid_o && ip_ready_i) begin
        if (ip_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL ip_spurious: got ipacket %0h want none", ipacket_o);
        end else chk("ip_data", ipacket_o, ip_exp.pop_front());
        ip_del++;
      end
    end
  end

  // Upstream drivers: hold valid and data until accepted.
  initial begin : p_drv
    bit take;
    p_valid_i = 1'b0; packet_i = '0;
    forever begin
      @(negedge clk_i); take = p_valid_i && p_ready_o && rst_ni;
      @(posedge clk_i); #1;
      if (!rst_ni) p_valid_i = 1'b0;
      else begin
        if (take) begin void'(p_stim.pop_front()); p_valid_i = 1'b0; end
        if (!p_valid_i && p_stim.size() != 0 && $urandom_range(0, 99) < p_gate) begin
          packet_i = Packet'(p_stim[0]);
          p_valid_i = 1'b1;
        end
      end
    end
  end

  initial begin : ip_drv
    bit take;
    ip_valid_i = 1'b0; ipacket_i = '0;
    forever begin
      @(negedge clk_i); take = ip_valid_i && ip_ready_o && rst_ni;
      @(posedge clk_i); #1;
      if (!rst_ni) ip_valid_i = 1'b0;
      else begin
        if (take) begin void'(ip_stim.pop_front()); ip_valid_i = 1'b0; end
        if (!ip_valid_i && ip_stim.size() != 0 && $urandom_range(0, 99) < ip_gate) begin
          ipacket_i = IPacket'(ip_stim[0]);
          ip_valid_i = 1'b1;
        end
      end
    end
  end

  // Random downstream ready; a mid-cycle ready_i flip must not move ready_o.
  initial begin : rdy_rnd
    logic r;
    forever begin
      @(posedge clk_i); #1;
      if (rnd) begin
        p_ready_i  = 1'($urandom_range(0, 1));
        ip_ready_i = 1'($urandom_range(0, 1));
        #1;
        r = p_ready_o;
        p_ready_i = ~p_ready_i;
        #1;
        chk("p_ready_comb", p_ready_o, r);
        p_ready_i = ~p_ready_i;
      end
    end
  end

  initial begin : main
    int t0, t1, n, base;
    logic prev;
    p_ready_i = 1'b0; ip_ready_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_p_valid", p_valid_o, 0);
    chk("rst_ip_valid", ip_valid_o, 0);
    chk("rst_p_ready", p_ready_o, 0);
    chk("rst_ip_ready", ip_ready_o, 0);
    chk("rst_packet", packet_o, 0);
    chk("rst_ipacket", ipacket_o, 0);
    chk("rst_p_occ", p_occ_o, 0);
    chk("rst_ip_occ", ip_occ_o, 0);
    chk("rst_p_cnt", p_cnt_o, 0);
    chk("rst_ip_cnt", ip_cnt_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;
    #1 chk("rel_p_ready_pre", p_ready_o, 0);
    @(posedge clk_i); #1;
    chk("rel_p_ready", p_ready_o, 1);
    chk("rel_ip_ready", ip_ready_o, 1);
    chk_occ = 1;

    // back-to-back stream: latency, throughput, steady occupancy
    p_ready_i = 1'b1; ip_ready_i = 1'b1;
    strm_max_occ = 0; strm_gaps = 0; strm_last = -1; strm = 1;
    for (int i = 1; i <= 10; i++) p_send(32'(i));
    n = 0;
    do begin @(negedge clk_i); n++; end while (!(p_valid_i && p_ready_o) && n < 20);
    t0 = cyc;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!p_valid_o && n < 20);
    t1 = cyc;
    chk("latency", t1 - t0, DEPTH);
    wait_drain("strm_drain", 40);
    strm = 0;
    chk("strm_gaps", strm_gaps, 0);
    chk("strm_max_occ", strm_max_occ, DEPTH);
    chk("strm_count", p_del, 10);
    chk_stats("strm");

    // backpressure fill
    p_ready_i = 1'b0;
    base = p_acc;
    for (int i = 1; i <= 6; i++) p_send(32'(i));
    prev = 1'b0; n = 0;
    while (p_acc - base != 4 && n < 30) begin
      prev = p_ready_o;
      @(posedge clk_i); #2;
      n++;
    end
    chk("bp_ready_before_4th", prev, 1);
    chk("bp_ready_fall", p_ready_o, 0);
    repeat (5) @(posedge clk_i);
    #2;
    chk("bp_accepted", p_acc - base, 4);
    chk("bp_occ", p_occ_o, 4);
    chk("bp_ready_held", p_ready_o, 0);
    chk("bp_pending", p_stim.size(), 2);
    p_ready_i = 1'b1;
    wait_drain("bp_drain", 40);

    // channel independence
    ip_ready_i = 1'b0;
    base = p_del;
    for (int i = 0; i < 8; i++) p_send(32'h100 + 32'(i));
    for (int i = 0; i < 6; i++) ip_send(16'h20 + 16'(i));
    n = 0;
    while (p_del - base != 8 && n < 40) begin @(posedge clk_i); #2; n++; end
    chk("ind_p_delivered", p_del - base, 8);
    repeat (3) @(posedge clk_i);
    #2;
    chk("ind_ip_occ", ip_occ_o, 2*DEPTH);
    chk("ind_ip_ready", ip_ready_o, 0);
    chk("ind_ip_pending", ip_stim.size(), 2);
    ip_ready_i = 1'b1;
    wait_drain("ind_drain", 40);

    // random valid/ready
    p_gate = 50; ip_gate = 70;
    for (int i = 0; i < 400; i++) begin
      p_send($urandom);
      ip_send(16'($urandom));
    end
    rnd = 1;
    n = 0;
    while ((p_stim.size() != 0 || ip_stim.size() != 0) && n < 20000) begin
      @(posedge clk_i); #2; n++;
    end
    chk("rnd_issued", p_stim.size() + ip_stim.size(), 0);
    rnd = 0;
    repeat (2) @(negedge clk_i);
    p_ready_i = 1'b1; ip_ready_i = 1'b1;
    p_gate = 100; ip_gate = 100;
    wait_drain("rnd_drain", 100);
    chk_stats("final");

    // reset with three packets buffered
    p_ready_i = 1'b0;
    base = p_acc;
    for (int i = 1; i <= 3; i++) p_send(32'h50 + 32'(i));
    n = 0;
    while (p_acc - base != 3 && n < 20) begin @(posedge clk_i); #2; n++; end
    repeat (2) @(posedge clk_i);
    #2;
    chk("mrst_occ_before", p_occ_o, 3);
    chk("mrst_valid_before", p_valid_o, 1);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    chk_occ = 0;
    #1;
    chk("mrst_p_valid", p_valid_o, 0);
    chk("mrst_packet", packet_o, 0);
    chk("mrst_p_occ", p_occ_o, 0);
    chk("mrst_p_ready", p_ready_o, 0);
    chk("mrst_ip_ready", ip_ready_o, 0);
    chk("mrst_p_cnt", p_cnt_o, 0);
    p_stim.delete(); p_exp.delete(); ip_stim.delete(); ip_exp.delete();
    p_acc = 0; p_del = 0; ip_acc = 0; ip_del = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    #1 chk("mrst_ready_pre", p_ready_o, 0);
    @(posedge clk_i); #1;
    chk("mrst_ready_post", p_ready_o, 1);
    chk_occ = 1;
    p_ready_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #2;
    chk("mrst_no_emit", p_valid_o, 0);
    chk("mrst_no_del", p_del, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
